// File: rtl/mem_stage_pkg.sv
// Shared types for the rvga MEM stage: word type, MEM FSM states and RV32I
// load/store funct3 encodings.
package mem_stage_pkg;

   typedef logic [31:0] rvga_word;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RESP,
      DONE
   } rvga_mem_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus valid-only read response.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic       dmem_v;
   logic       dmem_w;
   rvga_word   dmem_addr;
   logic [3:0] dmem_wmask;
   rvga_word   dmem_wdata;
   logic       dmem_ready;
   logic       dmem_rdata_v;
   rvga_word   dmem_rdata;

   modport master (
      output dmem_v, dmem_w, dmem_addr, dmem_wmask, dmem_wdata,
      input  dmem_ready, dmem_rdata_v, dmem_rdata
   );

   modport slave (
      input  dmem_v, dmem_w, dmem_addr, dmem_wmask, dmem_wdata,
      output dmem_ready, dmem_rdata_v, dmem_rdata
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half lane of a load word and sign- or
// zero-extends it according to funct3.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic [1:0] addr_lo_i,
   input  rvga_word   raw_i,
   output rvga_word   ext_o
);

   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   always_comb begin
      lane_b = '0;
      case (addr_lo_i)
         2'd0:    lane_b = raw_i[7:0];
         2'd1:    lane_b = raw_i[15:8];
         2'd2:    lane_b = raw_i[23:16];
         default: lane_b = raw_i[31:24];
      endcase
      lane_h = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

      ext_o = raw_i;
      case (funct3_i)
         LB:      ext_o = {{24{lane_b[7]}}, lane_b};
         LH:      ext_o = {{16{lane_h[15]}}, lane_h};
         LBU:     ext_o = {24'd0, lane_b};
         LHU:     ext_o = {16'd0, lane_h};
         default: ext_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rvga MEM stage: issues loads/stores to the data memory, aligns load data and
// stalls the front of the pipeline until the access completes.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int word_width_p = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ld_v_i,
   input  logic       st_v_i,
   input  logic [2:0] funct3_i,
   input  rvga_word   alu_result_i,
   input  rvga_word   st_data_i,
   input  logic       stall_i,
   mem_stage_if.master dmem,
   output rvga_word   alu_or_ld_result_o,
   output logic       stall_v_o,
   output logic       mem_exc_o
);

   rvga_mem_state_e state_q, state_n;
   rvga_word        held_q;
   rvga_word        ld_word;
   logic            capture;
   logic            mem;
   logic            misalign, ld_illegal, st_illegal;
   logic [1:0]      addr_lo;

   assign addr_lo = alu_result_i[1:0];

   always_comb begin
      misalign   = ((funct3_i == 3'b001 || funct3_i == 3'b101) && addr_lo[0])
                || (funct3_i == 3'b010 && addr_lo != 2'b00);
      ld_illegal = ld_v_i && (funct3_i inside {3'b011, 3'b110, 3'b111});
      st_illegal = st_v_i && !(funct3_i inside {SB, SH, SW});
      mem_exc_o  = (ld_v_i || st_v_i) && (misalign || ld_illegal || st_illegal);
      mem        = (ld_v_i || st_v_i) && !mem_exc_o;
   end

   // Request fields are pure functions of the held EX/MEM inputs, so they stay
   // stable for as long as the memory withholds ready.
   assign dmem.dmem_w    = st_v_i;
   assign dmem.dmem_addr = {alu_result_i[word_width_p-1:2], 2'b00};

   always_comb begin
      dmem.dmem_wmask = 4'b0000;
      dmem.dmem_wdata = st_data_i;
      if (st_v_i) begin
         case (funct3_i)
            SB: begin
               dmem.dmem_wmask = 4'b0001 << addr_lo;
               dmem.dmem_wdata = {4{st_data_i[7:0]}};
            end
            SH: begin
               dmem.dmem_wmask = 4'b0011 << addr_lo;
               dmem.dmem_wdata = {2{st_data_i[15:0]}};
            end
            default: begin
               dmem.dmem_wmask = 4'b1111;
               dmem.dmem_wdata = st_data_i;
            end
         endcase
      end
   end

   load_align u_load_align (
      .funct3_i  (funct3_i),
      .addr_lo_i (addr_lo),
      .raw_i     (dmem.dmem_rdata),
      .ext_o     (ld_word)
   );

   always_comb begin
      state_n            = state_q;
      dmem.dmem_v        = 1'b0;
      stall_v_o          = 1'b0;
      capture            = 1'b0;
      alu_or_ld_result_o = alu_result_i;
      case (state_q)
         IDLE: begin
            dmem.dmem_v = mem;
            if (mem) begin
               if (!dmem.dmem_ready) begin
                  stall_v_o = 1'b1;
               end else if (st_v_i) begin
                  state_n = stall_i ? DONE : IDLE;
               end else begin
                  stall_v_o = 1'b1;
                  state_n   = WAIT_RESP;
               end
            end
         end
         WAIT_RESP: begin
            if (dmem.dmem_rdata_v) begin
               alu_or_ld_result_o = ld_word;
               capture            = 1'b1;
               state_n            = stall_i ? DONE : IDLE;
            end else begin
               stall_v_o = 1'b1;
            end
         end
         DONE: begin
            // Frozen downstream: keep presenting the finished result, no re-issue.
            alu_or_ld_result_o = ld_v_i ? held_q : alu_result_i;
            if (!stall_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         held_q  <= '0;
      end else begin
         state_q <= state_n;
         if (capture) held_q <= ld_word;
      end
   end

endmodule
